wb_arbiter: RTL and testbench

- Parametrised writeback arbiter between NCH result producers (ALU lanes, load return, FPU units of differing latency) and a register file with NWP write ports.
- Each channel has a small FIFO, so producers completing in the same cycle never drop results.
- A rotating-priority grant drains up to NWP results per cycle, never more than one per destination register.
- A per-register pending vector gives the issue stage hazard visibility.

---
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained into NWP register-file
// write ports by a rotating-priority grant. No two grants in one cycle share
// a destination register.
module wb_arbiter #(
  parameter int NCH   = 8,
  parameter int NWP   = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interlock,
  input  logic [NCH-1:0]      in_valid,
  output logic [NCH-1:0]      in_ready,
  input  logic [NCH*AW-1:0]   in_rd,
  input  logic [NCH*XLEN-1:0] in_data,
  output logic [NWP-1:0]      wr_en,
  output logic [NWP*AW-1:0]   wr_addr,
  output logic [NWP*XLEN-1:0] wr_data,
  output logic [NREG-1:0]     pending,
  output logic                busy
);

  localparam int LW = $clog2(DEPTH);
  localparam int PW = LW + 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [AW-1:0]   q_rd      [NCH][DEPTH];
  logic [XLEN-1:0] q_data    [NCH][DEPTH];
  logic [PW-1:0]   wptr      [NCH];
  logic [PW-1:0]   rptr      [NCH];
  logic [AW-1:0]   head_rd   [NCH];
  logic [XLEN-1:0] head_data [NCH];
  logic [NCH-1:0]  empty, full, push, pop;
  logic [CW-1:0]   rr, rr_next;

  logic            g_valid [NWP];
  logic [AW-1:0]   g_rd    [NWP];
  logic [XLEN-1:0] g_data  [NWP];

  // FIFO status, heads and enqueue acceptance; rd==0 is accepted but dropped
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      empty[c]     = (wptr[c] == rptr[c]);
      full[c]      = (wptr[c][PW-1] != rptr[c][PW-1]) &&
                     (wptr[c][LW-1:0] == rptr[c][LW-1:0]);
      head_rd[c]   = q_rd[c][rptr[c][LW-1:0]];
      head_data[c] = q_data[c][rptr[c][LW-1:0]];
      in_ready[c]  = !rst && !full[c];
      push[c]      = in_valid[c] && in_ready[c] && (in_rd[c*AW +: AW] != '0);
    end
  end

  // Rotating-priority grant of up to NWP heads with distinct destinations
  always_comb begin
    int unsigned n;
    int unsigned ch;
    logic        clash;
    pop     = '0;
    rr_next = rr;
    n       = 0;
    ch      = 0;
    clash   = 1'b0;
    for (int unsigned p = 0; p < NWP; p++) begin
      g_valid[p] = 1'b0;
      g_rd[p]    = '0;
      g_data[p]  = '0;
    end
    if (!interlock) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        ch = (32'(rr) + k) % NCH;
        if (!empty[ch] && n < NWP) begin
          clash = 1'b0;
          for (int unsigned p = 0; p < NWP; p++)
            if (p < n && g_rd[p] == head_rd[ch]) clash = 1'b1;
          if (!clash) begin
            g_valid[n] = 1'b1;
            g_rd[n]    = head_rd[ch];
            g_data[n]  = head_data[ch];
            pop[ch]    = 1'b1;
            rr_next    = CW'((ch + 1) % NCH);
            n          = n + 1;
          end
        end
      end
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (push[c]) begin
          q_rd[c][wptr[c][LW-1:0]]   <= in_rd[c*AW +: AW];
          q_data[c][wptr[c][LW-1:0]] <= in_data[c*XLEN +: XLEN];
          wptr[c]                    <= wptr[c] + 1'b1;
        end
        if (pop[c]) rptr[c] <= rptr[c] + 1'b1;
      end
    end
  end

  // Registered write ports and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      rr      <= '0;
    end else begin
      for (int unsigned p = 0; p < NWP; p++) begin
        wr_en[p]                 <= g_valid[p];
        wr_addr[p*AW +: AW]      <= g_rd[p];
        wr_data[p*XLEN +: XLEN]  <= g_data[p];
      end
      rr <= rr_next;
    end
  end

  // Pending vector: occupied FIFO slots plus live write ports
  always_comb begin
    logic [LW-1:0] off;
    logic [PW-1:0] cnt;
    pending = '0;
    off     = '0;
    cnt     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      cnt = wptr[c] - rptr[c];
      for (int unsigned i = 0; i < DEPTH; i++) begin
        off = LW'(i) - rptr[c][LW-1:0];
        if ({1'b0, off} < cnt) pending[q_rd[c][i]] = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NWP; p++)
      if (wr_en[p]) pending[wr_addr[p*AW +: AW]] = 1'b1;
    pending[0] = 1'b0;
  end

  // Busy while anything is buffered or being written
  always_comb begin
    busy = !(&empty) || (|wr_en);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with default parameters (NCH=8, NWP=2,
// DEPTH=4, XLEN=32, NREG=32, AW=5). Stimulus is applied and outputs are
// sampled 1ns after each rising edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interlock = 1'b0;
  logic [7:0]  in_valid = '0;
  logic [7:0]  in_ready;
  logic [39:0] in_rd = '0;
  logic [255:0] in_data = '0;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] pending;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  wb_arbiter #(.NCH(8), .NWP(2), .DEPTH(4), .XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .interlock(interlock),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [4:0] rd, input logic [31:0] d);
    in_valid[c]        = 1'b1;
    in_rd[c*5 +: 5]    = rd;
    in_data[c*32 +: 32] = d;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_rd    = '0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    interlock = 1'b0;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vecs++; if (wr_en !== 2'b00) begin errs++; $display("FAIL reset_wr_en got %b want 00", wr_en); end
    vecs++; if (pending !== 32'h0) begin errs++; $display("FAIL reset_pending got %h want 0", pending); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (in_ready !== 8'h00) begin errs++; $display("FAIL reset_in_ready got %h want 00", in_ready); end
    rst = 1'b0;
    #1;
    vecs++; if (in_ready !== 8'hFF) begin errs++; $display("FAIL post_reset_in_ready got %h want ff", in_ready); end
    tick();
  endtask

  task automatic test_single();
    set_ch(2, 5'd7, 32'hDEADBEEF);
    tick();
    clear_in();
    vecs++; if (wr_en !== 2'b00) begin errs++; $display("FAIL single_e0_wr_en got %b want 00", wr_en); end
    vecs++; if (pending !== 32'h80) begin errs++; $display("FAIL single_e0_pending got %h want 80", pending); end
    tick();
    vecs++; if (wr_en !== 2'b01) begin errs++; $display("FAIL single_wr_en got %b want 01", wr_en); end
    vecs++; if (wr_addr[4:0] !== 5'd7) begin errs++; $display("FAIL single_addr got %0d want 7", wr_addr[4:0]); end
    vecs++; if (wr_data[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL single_data got %h want deadbeef", wr_data[31:0]); end
    vecs++; if (pending !== 32'h80) begin errs++; $display("FAIL single_e1_pending got %h want 80", pending); end
    tick();
    vecs++; if (wr_en !== 2'b00) begin errs++; $display("FAIL single_e2_wr_en got %b want 00", wr_en); end
    vecs++; if (pending !== 32'h0) begin errs++; $display("FAIL single_e2_pending got %h want 0", pending); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_e2_busy got %b want 0", busy); end
  endtask

  task automatic test_contention();
    do_reset();
    set_ch(0, 5'd1, 32'hA0);
    set_ch(3, 5'd2, 32'hA3);
    set_ch(5, 5'd3, 32'hA5);
    tick();
    clear_in();
    vecs++; if (pending !== 32'hE) begin errs++; $display("FAIL cont_pending0 got %h want e", pending); end
    tick();
    vecs++; if (wr_en !== 2'b11) begin errs++; $display("FAIL cont_w1_en got %b want 11", wr_en); end
    vecs++; if (wr_addr !== {5'd2, 5'd1}) begin errs++; $display("FAIL cont_w1_addr got %h want %h", wr_addr, {5'd2, 5'd1}); end
    vecs++; if (wr_data !== {32'hA3, 32'hA0}) begin errs++; $display("FAIL cont_w1_data got %h want %h", wr_data, {32'hA3, 32'hA0}); end
    vecs++; if (pending !== 32'hE) begin errs++; $display("FAIL cont_pending1 got %h want e", pending); end
    tick();
    vecs++; if (wr_en !== 2'b01) begin errs++; $display("FAIL cont_w2_en got %b want 01", wr_en); end
    vecs++; if (wr_addr[4:0] !== 5'd3) begin errs++; $display("FAIL cont_w2_addr got %0d want 3", wr_addr[4:0]); end
    vecs++; if (wr_data[31:0] !== 32'hA5) begin errs++; $display("FAIL cont_w2_data got %h want a5", wr_data[31:0]); end
    // rr should now be 6: ch7 outranks ch0 in the next scan
    set_ch(0, 5'd4, 32'hB0);
    set_ch(7, 5'd5, 32'hB7);
    tick();
    clear_in();
    tick();
    vecs++; if (wr_en !== 2'b11) begin errs++; $display("FAIL rr6_en got %b want 11", wr_en); end
    vecs++; if (wr_addr !== {5'd4, 5'd5}) begin errs++; $display("FAIL rr6_addr got %h want %h", wr_addr, {5'd4, 5'd5}); end
    tick();
  endtask

  task automatic test_same_reg();
    do_reset();
    set_ch(1, 5'd9, 32'h11);
    set_ch(4, 5'd9, 32'h44);
    tick();
    clear_in();
    tick();
    vecs++; if (wr_en !== 2'b01) begin errs++; $display("FAIL samereg_w1_en got %b want 01", wr_en); end
    vecs++; if (wr_addr[4:0] !== 5'd9 || wr_data[31:0] !== 32'h11) begin errs++; $display("FAIL samereg_w1 got r%0d=%h want r9=11", wr_addr[4:0], wr_data[31:0]); end
    tick();
    vecs++; if (wr_en !== 2'b01) begin errs++; $display("FAIL samereg_w2_en got %b want 01", wr_en); end
    vecs++; if (wr_addr[4:0] !== 5'd9 || wr_data[31:0] !== 32'h44) begin errs++; $display("FAIL samereg_w2 got r%0d=%h want r9=44", wr_addr[4:0], wr_data[31:0]); end
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL samereg_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    interlock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ch(6, 5'(10 + i), 32'(32'h600 + i));
      #1;
      vecs++; if (in_ready[6] !== (i < 4)) begin errs++; $display("FAIL bp_ready_%0d got %b want %b", i, in_ready[6], (i < 4)); end
      tick();
      vecs++; if (wr_en !== 2'b00) begin errs++; $display("FAIL bp_interlock_en_%0d got %b want 00", i, wr_en); end
    end
    clear_in();
    vecs++; if (pending !== 32'h3C00) begin errs++; $display("FAIL bp_pending got %h want 3c00", pending); end
    interlock = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      vecs++; if (wr_en !== 2'b01 || wr_addr[4:0] !== 5'(10 + j) || wr_data[31:0] !== 32'(32'h600 + j))
        begin errs++; $display("FAIL bp_drain_%0d got en=%b r%0d=%h want en=01 r%0d=%h", j, wr_en, wr_addr[4:0], wr_data[31:0], 10 + j, 32'h600 + j); end
    end
    // producer now re-presents the held results
    set_ch(6, 5'd14, 32'h604);
    tick();
    set_ch(6, 5'd15, 32'h605);
    tick();
    clear_in();
    vecs++; if (wr_en !== 2'b01 || wr_addr[4:0] !== 5'd14) begin errs++; $display("FAIL bp_r14 got en=%b r%0d want en=01 r14", wr_en, wr_addr[4:0]); end
    tick();
    vecs++; if (wr_en !== 2'b01 || wr_addr[4:0] !== 5'd15) begin errs++; $display("FAIL bp_r15 got en=%b r%0d want en=01 r15", wr_en, wr_addr[4:0]); end
    tick();
  endtask

  task automatic test_rd0_and_reset();
    do_reset();
    set_ch(0, 5'd0, 32'h123);
    #1;
    vecs++; if (in_ready[0] !== 1'b1) begin errs++; $display("FAIL rd0_ready got %b want 1", in_ready[0]); end
    tick();
    clear_in();
    vecs++; if (pending !== 32'h0 || busy !== 1'b0) begin errs++; $display("FAIL rd0_state got pending=%h busy=%b want 0/0", pending, busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (wr_en !== 2'b00) begin errs++; $display("FAIL rd0_wr_en_%0d got %b want 00", i, wr_en); end
    end
    for (int c = 0; c < 4; c++) set_ch(c, 5'(20 + c), 32'(32'hC0 + c));
    tick();
    for (int c = 0; c < 4; c++) set_ch(c, 5'(24 + c), 32'(32'hD0 + c));
    tick();
    clear_in();
    vecs++; if (wr_en !== 2'b11 || wr_addr !== {5'd21, 5'd20}) begin errs++; $display("FAIL mid_drain got en=%b addr=%h want 11 %h", wr_en, wr_addr, {5'd21, 5'd20}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (wr_en !== 2'b00 || busy !== 1'b0 || pending !== 32'h0)
      begin errs++; $display("FAIL rst_mid got en=%b busy=%b pending=%h want 00 0 0", wr_en, busy, pending); end
    for (int i = 0; i < 6; i++) begin
      tick();
      vecs++; if (wr_en !== 2'b00) begin errs++; $display("FAIL rst_discard_%0d got %b want 00", i, wr_en); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_same_reg();
    test_backpressure();
    test_rd0_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
